// File: rtl/block_pkg.sv
// Shared types and helpers for the block packer datapath.
package block_pkg;

  localparam int unsigned BLOCK_SIZE = 64;

  typedef logic [BLOCK_SIZE-1:0] block_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  // Limit a lane count to the number of physical input lanes.
  function automatic logic [31:0] clamp_num(input logic [31:0] num, input logic [31:0] max_num);
    return (num > max_num) ? max_num : num;
  endfunction

endpackage

// File: rtl/block_packer_if.sv
// Input and output beat streams of the block packer.
interface block_packer_if #(
  parameter int unsigned IN_BLOCKS  = 2,
  parameter int unsigned OUT_BLOCKS = 4
) ();
  import block_pkg::*;

  logic                             in_valid;
  logic                             in_ready;
  logic [IN_BLOCKS*BLOCK_SIZE-1:0]  in_data;
  logic [31:0]                      in_num;
  logic                             in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [OUT_BLOCKS*BLOCK_SIZE-1:0] out_data;
  logic [31:0]                      out_num;
  logic                             out_last;

  // Packer side: consumes input beats, produces output beats.
  modport slave (
    input  in_valid, in_data, in_num, in_last, out_ready,
    output in_ready, out_valid, out_data, out_num, out_last
  );

  // Environment side: produces input beats, consumes output beats.
  modport master (
    output in_valid, in_data, in_num, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_num, out_last
  );

endinterface

// File: rtl/block_merge_buf.sv
// Combinational insert-at-cnt of the accepted lanes into the residual buffer,
// followed by the split into an emitted beat and the shifted-down remainder.
module block_merge_buf
  import block_pkg::*;
#(
  parameter int unsigned IN_BLOCKS  = 2,
  parameter int unsigned OUT_BLOCKS = 4,
  parameter int unsigned BUF_BLOCKS = OUT_BLOCKS + IN_BLOCKS - 1,
  parameter int unsigned CNT_W      = $clog2(OUT_BLOCKS + IN_BLOCKS)
) (
  input  block_t [BUF_BLOCKS-1:0] buf_blk,
  input  logic   [CNT_W-1:0]      cnt,
  input  block_t [IN_BLOCKS-1:0]  in_blk,
  input  logic   [CNT_W-1:0]      in_n,
  input  logic                    ins,
  output block_t [BUF_BLOCKS-1:0] nxt_buf,
  output logic   [CNT_W-1:0]      nxt_cnt,
  output block_t [OUT_BLOCKS-1:0] emit_data,
  output logic   [CNT_W-1:0]      emit_num,
  output logic                    full
);

  block_t [BUF_BLOCKS-1:0]            merged_s;
  block_t [BUF_BLOCKS+OUT_BLOCKS-1:0] ext_s;
  logic   [CNT_W-1:0]                 add_s;
  logic   [CNT_W-1:0]                 tot_s;

  assign add_s = ins ? in_n : {CNT_W{1'b0}};
  assign tot_s = cnt + add_s;
  assign full  = (tot_s >= CNT_W'(OUT_BLOCKS));

  // Drop the accepted lanes into the residual directly after its newest block.
  always_comb begin
    merged_s = buf_blk;
    for (int k = 0; k < BUF_BLOCKS; k++) begin
      for (int i = 0; i < IN_BLOCKS; i++) begin
        merged_s[k] = ((CNT_W'(i) < add_s) && (CNT_W'(k) == cnt + CNT_W'(i))) ? in_blk[i] : merged_s[k];
      end
    end
  end

  // Zero padding above the buffer so the shift-down never reads past its end.
  assign ext_s = {{(OUT_BLOCKS*BLOCK_SIZE){1'b0}}, merged_s};

  // Split into the beat to emit (unused lanes zeroed) and the residual left behind.
  always_comb begin
    emit_num = full ? CNT_W'(OUT_BLOCKS) : tot_s;
    nxt_cnt  = full ? (tot_s - CNT_W'(OUT_BLOCKS)) : tot_s;
    for (int j = 0; j < OUT_BLOCKS; j++) begin
      emit_data[j] = (CNT_W'(j) < emit_num) ? merged_s[j] : {BLOCK_SIZE{1'b0}};
    end
    for (int k = 0; k < BUF_BLOCKS; k++) begin
      nxt_buf[k] = full ? ext_s[k+OUT_BLOCKS] : merged_s[k];
    end
  end

endmodule

// File: rtl/block_packer.sv
// Repacks sparse input beats of up to IN_BLOCKS blocks into full OUT_BLOCKS-wide
// output beats, carrying leftovers across beats and flushing them on in_last.
module block_packer
  import block_pkg::*;
#(
  parameter int unsigned IN_BLOCKS  = 2,
  parameter int unsigned OUT_BLOCKS = 4
) (
  input logic           clk,
  input logic           rst,
  block_packer_if.slave bus
);

  localparam int unsigned BUF_BLOCKS = OUT_BLOCKS + IN_BLOCKS - 1;
  localparam int unsigned CNT_W      = $clog2(OUT_BLOCKS + IN_BLOCKS);

  generate
    if ((OUT_BLOCKS < IN_BLOCKS) || (IN_BLOCKS < 32'd1)) begin : g_param_check
      $error("block_packer: OUT_BLOCKS must be >= IN_BLOCKS and IN_BLOCKS >= 1");
    end
  endgenerate

  pack_state_t             state_r;
  pack_state_t             state_nxt_s;
  block_t [BUF_BLOCKS-1:0] buf_r;
  block_t [BUF_BLOCKS-1:0] buf_nxt_s;
  block_t [BUF_BLOCKS-1:0] mrg_buf_s;
  logic   [CNT_W-1:0]      cnt_r;
  logic   [CNT_W-1:0]      cnt_nxt_s;
  logic   [CNT_W-1:0]      mrg_cnt_s;
  logic   [CNT_W-1:0]      n_s;
  logic   [CNT_W-1:0]      emit_num_s;
  block_t [OUT_BLOCKS-1:0] emit_data_s;
  block_t [OUT_BLOCKS-1:0] out_data_r;
  block_t [OUT_BLOCKS-1:0] out_data_nxt_s;
  logic   [CNT_W-1:0]      out_num_r;
  logic   [CNT_W-1:0]      out_num_nxt_s;
  logic                    out_valid_r;
  logic                    out_valid_nxt_s;
  logic                    out_last_r;
  logic                    out_last_nxt_s;
  logic                    slot_free_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    full_s;
  block_t [IN_BLOCKS-1:0]  in_blk_s;

  assign in_blk_s    = bus.in_data;
  assign n_s         = CNT_W'(clamp_num(bus.in_num, 32'(IN_BLOCKS)));
  assign slot_free_s = ~out_valid_r | bus.out_ready;
  assign in_ready_s  = slot_free_s & (state_r == RUN);
  assign accept_s    = bus.in_valid & in_ready_s;

  block_merge_buf #(
    .IN_BLOCKS (IN_BLOCKS),
    .OUT_BLOCKS(OUT_BLOCKS),
    .BUF_BLOCKS(BUF_BLOCKS),
    .CNT_W     (CNT_W)
  ) u_merge (
    .buf_blk  (buf_r),
    .cnt      (cnt_r),
    .in_blk   (in_blk_s),
    .in_n     (n_s),
    .ins      (accept_s),
    .nxt_buf  (mrg_buf_s),
    .nxt_cnt  (mrg_cnt_s),
    .emit_data(emit_data_s),
    .emit_num (emit_num_s),
    .full     (full_s)
  );

  // Next-state and output-register load decisions; holds everything by default.
  always_comb begin
    state_nxt_s     = state_r;
    buf_nxt_s       = buf_r;
    cnt_nxt_s       = cnt_r;
    out_valid_nxt_s = out_valid_r;
    out_data_nxt_s  = out_data_r;
    out_num_nxt_s   = out_num_r;
    out_last_nxt_s  = out_last_r;
    case (state_r)
      RUN: begin
        if (accept_s) begin
          if (full_s) begin
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = emit_data_s;
            out_num_nxt_s   = emit_num_s;
            out_last_nxt_s  = bus.in_last & (mrg_cnt_s == {CNT_W{1'b0}});
            buf_nxt_s       = mrg_buf_s;
            cnt_nxt_s       = mrg_cnt_s;
            if (bus.in_last && (mrg_cnt_s != {CNT_W{1'b0}})) begin
              state_nxt_s = FLUSH;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (bus.in_last) begin
            // Short final beat: everything buffered goes out now, possibly empty.
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = emit_data_s;
            out_num_nxt_s   = emit_num_s;
            out_last_nxt_s  = 1'b1;
            buf_nxt_s       = {(BUF_BLOCKS*BLOCK_SIZE){1'b0}};
            cnt_nxt_s       = {CNT_W{1'b0}};
          end else begin
            // Not enough blocks yet; the previous beat (if any) was taken this cycle.
            out_valid_nxt_s = 1'b0;
            buf_nxt_s       = mrg_buf_s;
            cnt_nxt_s       = mrg_cnt_s;
          end
        end else if (slot_free_s) begin
          out_valid_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = out_valid_r;
        end
      end
      FLUSH: begin
        if (slot_free_s) begin
          out_valid_nxt_s = 1'b1;
          out_data_nxt_s  = emit_data_s;
          out_num_nxt_s   = emit_num_s;
          out_last_nxt_s  = 1'b1;
          buf_nxt_s       = {(BUF_BLOCKS*BLOCK_SIZE){1'b0}};
          cnt_nxt_s       = {CNT_W{1'b0}};
          state_nxt_s     = RUN;
        end else begin
          state_nxt_s     = FLUSH;
        end
      end
      default: begin
        state_nxt_s     = RUN;
        buf_nxt_s       = {(BUF_BLOCKS*BLOCK_SIZE){1'b0}};
        cnt_nxt_s       = {CNT_W{1'b0}};
        out_valid_nxt_s = 1'b0;
        out_data_nxt_s  = {(OUT_BLOCKS*BLOCK_SIZE){1'b0}};
        out_num_nxt_s   = {CNT_W{1'b0}};
        out_last_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, residual buffer and output register, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      buf_r       <= {(BUF_BLOCKS*BLOCK_SIZE){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {(OUT_BLOCKS*BLOCK_SIZE){1'b0}};
      out_num_r   <= {CNT_W{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      buf_r       <= buf_nxt_s;
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_num_r   <= out_num_nxt_s;
      out_last_r  <= out_last_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_num   = {{(32-CNT_W){1'b0}}, out_num_r};
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_block_packer.sv
// Directed self-checking bench for block_packer (IN_BLOCKS=2, OUT_BLOCKS=4).
module tb_block_packer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  block_packer_if #(.IN_BLOCKS(2), .OUT_BLOCKS(4)) bus_if ();

  block_packer #(.IN_BLOCKS(2), .OUT_BLOCKS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  function automatic logic [63:0] bk(input logic [7:0] t);
    return {8{t}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] l1, input logic [63:0] l0,
                       input logic [31:0] n, input logic last);
    bus_if.in_valid = v;
    bus_if.in_data  = {l1, l0};
    bus_if.in_num   = n;
    bus_if.in_last  = last;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [255:0] d,
                          input logic [31:0] n, input logic last);
    chk1({tag, "_valid"}, bus_if.out_valid, v);
    chk256({tag, "_data"}, bus_if.out_data, d);
    chk32({tag, "_num"}, bus_if.out_num, n);
    chk1({tag, "_last"}, bus_if.out_last, last);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.out_ready = 1'b1;
    drive(1'b0, 64'h0, 64'h0, 32'd0, 1'b0);
    tick();
    tick();
    // Reset state
    chk_beat("reset", 1'b0, 256'h0, 32'd0, 1'b0);
    chk1("reset_in_ready", bus_if.in_ready, 1'b1);
    rst = 1'b0;

    // Two full input beats make one output beat
    drive(1'b1, bk(8'hA1), bk(8'hA0), 32'd2, 1'b0);
    tick();
    chk1("t2_partial_valid", bus_if.out_valid, 1'b0);
    drive(1'b1, bk(8'hB1), bk(8'hB0), 32'd2, 1'b0);
    tick();
    chk_beat("t2", 1'b1, {bk(8'hB1), bk(8'hB0), bk(8'hA1), bk(8'hA0)}, 32'd4, 1'b0);
    drive(1'b0, 64'h0, 64'h0, 32'd0, 1'b0);
    tick();
    chk1("t2_drain_valid", bus_if.out_valid, 1'b0);

    // n=1,2,2 leaves C1 behind; empty last beat flushes it
    drive(1'b1, bk(8'hEE), bk(8'hA0), 32'd1, 1'b0);
    tick();
    chk1("t3_partial_valid", bus_if.out_valid, 1'b0);
    drive(1'b1, bk(8'hB1), bk(8'hB0), 32'd2, 1'b0);
    tick();
    drive(1'b1, bk(8'hC1), bk(8'hC0), 32'd2, 1'b0);
    tick();
    chk_beat("t3a", 1'b1, {bk(8'hC0), bk(8'hB1), bk(8'hB0), bk(8'hA0)}, 32'd4, 1'b0);
    drive(1'b1, bk(8'hEE), bk(8'hEE), 32'd0, 1'b1);
    tick();
    chk_beat("t3b", 1'b1, {64'h0, 64'h0, 64'h0, bk(8'hC1)}, 32'd1, 1'b1);
    drive(1'b0, 64'h0, 64'h0, 32'd0, 1'b0);
    tick();
    chk1("t3_drain_valid", bus_if.out_valid, 1'b0);

    // cnt=3 then last beat of 2 -> full beat, one-cycle FLUSH, residual beat
    drive(1'b1, bk(8'hD1), bk(8'hD0), 32'd2, 1'b0);
    tick();
    drive(1'b1, bk(8'hEE), bk(8'hD2), 32'd1, 1'b0);
    tick();
    drive(1'b1, bk(8'hE1), bk(8'hE0), 32'd2, 1'b1);
    tick();
    chk_beat("t4a", 1'b1, {bk(8'hE0), bk(8'hD2), bk(8'hD1), bk(8'hD0)}, 32'd4, 1'b0);
    drive(1'b1, bk(8'hF1), bk(8'hF0), 32'd2, 1'b0);
    #1;
    chk1("t4_flush_in_ready", bus_if.in_ready, 1'b0);
    tick();
    chk_beat("t4b", 1'b1, {64'h0, 64'h0, 64'h0, bk(8'hE1)}, 32'd1, 1'b1);
    chk1("t4_after_in_ready", bus_if.in_ready, 1'b1);
    tick();
    chk1("t4_f_partial_valid", bus_if.out_valid, 1'b0);

    // Backpressure holds the output beat stable
    drive(1'b1, bk(8'hF3), bk(8'hF2), 32'd2, 1'b0);
    tick();
    chk_beat("t5_beat", 1'b1, {bk(8'hF3), bk(8'hF2), bk(8'hF1), bk(8'hF0)}, 32'd4, 1'b0);
    bus_if.out_ready = 1'b0;
    drive(1'b1, bk(8'hC5), bk(8'hC4), 32'd2, 1'b0);
    #1;
    chk1("t5_stall_in_ready", bus_if.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat("t5_hold", 1'b1, {bk(8'hF3), bk(8'hF2), bk(8'hF1), bk(8'hF0)}, 32'd4, 1'b0);
      chk1("t5_hold_in_ready", bus_if.in_ready, 1'b0);
    end
    bus_if.out_ready = 1'b1;
    #1;
    chk1("t5_release_in_ready", bus_if.in_ready, 1'b1);
    tick();
    chk1("t5_partial_valid", bus_if.out_valid, 1'b0);
    drive(1'b1, bk(8'hC7), bk(8'hC6), 32'd2, 1'b0);
    tick();
    chk_beat("t5_next", 1'b1, {bk(8'hC7), bk(8'hC6), bk(8'hC5), bk(8'hC4)}, 32'd4, 1'b0);

    // in_num above IN_BLOCKS is clamped
    drive(1'b1, bk(8'h91), bk(8'h90), 32'd7, 1'b0);
    tick();
    chk1("clamp_partial_valid", bus_if.out_valid, 1'b0);
    drive(1'b1, bk(8'h93), bk(8'h92), 32'd2, 1'b0);
    tick();
    chk_beat("clamp", 1'b1, {bk(8'h93), bk(8'h92), bk(8'h91), bk(8'h90)}, 32'd4, 1'b0);

    // Empty last beat with nothing buffered
    drive(1'b1, bk(8'hEE), bk(8'hEE), 32'd0, 1'b1);
    tick();
    chk_beat("t6_empty", 1'b1, 256'h0, 32'd0, 1'b1);

    // Reset while in FLUSH discards the residual
    drive(1'b1, bk(8'h51), bk(8'h50), 32'd2, 1'b0);
    tick();
    drive(1'b1, bk(8'hEE), bk(8'h52), 32'd1, 1'b0);
    tick();
    drive(1'b1, bk(8'h54), bk(8'h53), 32'd2, 1'b1);
    tick();
    chk_beat("t7_full", 1'b1, {bk(8'h53), bk(8'h52), bk(8'h51), bk(8'h50)}, 32'd4, 1'b0);
    drive(1'b0, 64'h0, 64'h0, 32'd0, 1'b0);
    rst = 1'b1;
    tick();
    chk_beat("t7_rst", 1'b0, 256'h0, 32'd0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    chk_beat("t7_idle", 1'b0, 256'h0, 32'd0, 1'b0);
    chk1("t7_in_ready", bus_if.in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
